// File: rtl/lcd_pkg.sv
// Shared constants for the LCD timing/pattern generator: mode encodings,
// run-state encoding, default 800x480 panel timing and the colour-bar table.
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'b00,
        MODE_BARS  = 2'b01,
        MODE_CHECK = 2'b10,
        MODE_RAMP  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10
    } run_state_e;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_SYNC   = 1;
    localparam int DEF_H_BP     = 45;
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 210;
    localparam int DEF_V_SYNC   = 1;
    localparam int DEF_V_BP     = 22;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 22;
    localparam int DEF_SYNC_POL = 0;
    localparam int DEF_CW       = 8;

    // {R,G,B} on/off per bar, bar 0 in the low bits: white, yellow, cyan,
    // green, magenta, red, blue, black.
    localparam logic [23:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101,
                                         3'b010, 3'b011, 3'b110, 3'b111};

    function automatic logic [2:0] bar_bits(input logic [2:0] idx);
        return BAR_TABLE[3 * int'(idx) +: 3];
    endfunction

endpackage

// File: rtl/lcd_pattern_rom.sv
// Combinational test-pattern source: maps the active-area coordinate and the
// frame's shadowed mode to a pixel colour. Needs XW, YW >= 6 for the checkerboard.
module lcd_pattern_rom
    import lcd_pkg::*;
#(
    parameter int CW       = 8,
    parameter int XW       = 11,
    parameter int YW       = 10,
    parameter int H_ACTIVE = 800
) (
    input  mode_e              mode,
    input  logic [XW-1:0]      x,
    input  logic [YW-1:0]      y,
    input  logic [3*CW-1:0]    fg_rgb,
    output logic [3*CW-1:0]    rgb
);

    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [XW-1:0] bar_full_s;
    logic [2:0]    bar_idx_s;
    logic [2:0]    bar_on_s;
    logic [CW-1:0] ramp_s;
    logic          check_odd_s;

    // Pattern selection
    always_comb begin
        bar_full_s  = x / XW'(BAR_W);
        bar_idx_s   = (bar_full_s > XW'(7)) ? 3'd7 : bar_full_s[2:0];
        bar_on_s    = bar_bits(bar_idx_s);
        ramp_s      = CW'(({CW'(0), x} << CW) / (XW + CW)'(H_ACTIVE));
        check_odd_s = ((x & XW'(32)) != XW'(0)) ^ ((y & YW'(32)) != YW'(0));
        rgb         = fg_rgb;
        case (mode)
            MODE_SOLID: rgb = fg_rgb;
            MODE_BARS:  rgb = {{CW{bar_on_s[2]}}, {CW{bar_on_s[1]}}, {CW{bar_on_s[0]}}};
            MODE_CHECK: rgb = check_odd_s ? {(3 * CW){1'b0}} : fg_rgb;
            MODE_RAMP:  rgb = {ramp_s, ramp_s, ramp_s};
            default:    rgb = fg_rgb;
        endcase
    end

endmodule

// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised LCD panel timing generator: pixel-clock divider, h/v counters,
// sync/DEN generation and frame-synchronous test pattern output.
module lcd_timing_pattern_gen
    import lcd_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int SYNC_POL = DEF_SYNC_POL,
    parameter int CW       = DEF_CW,
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP,
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [1:0]        MODE,
    input  logic [3*CW-1:0]   FG_RGB,
    output logic              NCLK,
    output logic              GREST,
    output logic              HD,
    output logic              VD,
    output logic              DEN,
    output logic [CW-1:0]     R,
    output logic [CW-1:0]     G,
    output logic [CW-1:0]     B,
    output logic [XW-1:0]     X,
    output logic [YW-1:0]     Y,
    output logic [15:0]       FRAME_CNT,
    output logic              FRAME_STB
);

    localparam int   DW       = $clog2(CLK_DIV);
    localparam int   HALF     = CLK_DIV / 2;
    localparam int   HA_START = H_SYNC + H_BP;
    localparam int   HA_END   = HA_START + H_ACTIVE;
    localparam int   VA_START = V_SYNC + V_BP;
    localparam int   VA_END   = VA_START + V_ACTIVE;
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [DW-1:0]   div_cnt_r, div_nxt_s;
    logic            tick_s, nclk_r;
    run_state_e      state_r, state_nxt_s;
    logic [XW-1:0]   h_r, h_nxt_s, x_nxt_s, x_r;
    logic [YW-1:0]   v_r, v_nxt_s, y_nxt_s, y_r;
    mode_e           mode_r, mode_nxt_s;
    logic            present_s, frame_end_s, den_nxt_s, hs_s, vs_s;
    logic [3*CW-1:0] pat_rgb_s, rgb_r;
    logic            grest_r, hd_r, vd_r, den_r, frame_stb_r;
    logic [15:0]     frame_cnt_r;

    // Pixel-clock divider; tick is the CLK cycle where NCLK falls
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt_r <= DW'(0);
            nclk_r    <= 1'b0;
        end else begin
            div_cnt_r <= div_nxt_s;
            nclk_r    <= (int'(div_nxt_s) >= HALF);
        end
    end

    // Run FSM and raster counters; ARM holds the panel idle for one tick after GREST rises
    always_comb begin
        tick_s      = (div_cnt_r == DW'(CLK_DIV - 1));
        div_nxt_s   = tick_s ? DW'(0) : div_cnt_r + DW'(1);
        state_nxt_s = state_r;
        h_nxt_s     = h_r;
        v_nxt_s     = v_r;
        present_s   = 1'b0;
        frame_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (EN) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                h_nxt_s = XW'(0);
                v_nxt_s = YW'(0);
            end
            ST_ARM: begin
                if (EN) begin
                    state_nxt_s = ST_RUN;
                    present_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                h_nxt_s = XW'(0);
                v_nxt_s = YW'(0);
            end
            ST_RUN: begin
                if (!EN) begin
                    state_nxt_s = ST_IDLE;
                    h_nxt_s     = XW'(0);
                    v_nxt_s     = YW'(0);
                end else if (int'(h_r) == H_TOTAL - 1) begin
                    present_s = 1'b1;
                    h_nxt_s   = XW'(0);
                    if (int'(v_r) == V_TOTAL - 1) begin
                        v_nxt_s     = YW'(0);
                        frame_end_s = 1'b1;
                    end else begin
                        v_nxt_s = v_r + YW'(1);
                    end
                end else begin
                    present_s = 1'b1;
                    h_nxt_s   = h_r + XW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                h_nxt_s     = XW'(0);
                v_nxt_s     = YW'(0);
            end
        endcase
    end

    // Next-pixel timing decode; outputs are registered from these so DEN, X, Y and RGB align
    always_comb begin
        hs_s       = present_s && (int'(h_nxt_s) < H_SYNC);
        vs_s       = present_s && (int'(v_nxt_s) < V_SYNC);
        den_nxt_s  = present_s
                     && (int'(h_nxt_s) >= HA_START) && (int'(h_nxt_s) < HA_END)
                     && (int'(v_nxt_s) >= VA_START) && (int'(v_nxt_s) < VA_END);
        x_nxt_s    = den_nxt_s ? h_nxt_s - XW'(HA_START) : XW'(0);
        y_nxt_s    = den_nxt_s ? v_nxt_s - YW'(VA_START) : YW'(0);
        mode_nxt_s = (present_s && h_nxt_s == XW'(0) && v_nxt_s == YW'(0)) ? mode_e'(MODE) : mode_r;
    end

    lcd_pattern_rom #(
        .CW       (CW),
        .XW       (XW),
        .YW       (YW),
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_rom (
        .mode   (mode_nxt_s),
        .x      (x_nxt_s),
        .y      (y_nxt_s),
        .fg_rgb (FG_RGB),
        .rgb    (pat_rgb_s)
    );

    // Panel-side registers, advanced only on the pixel tick
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            h_r         <= XW'(0);
            v_r         <= YW'(0);
            mode_r      <= MODE_SOLID;
            grest_r     <= 1'b0;
            hd_r        <= ~SYNC_ACT;
            vd_r        <= ~SYNC_ACT;
            den_r       <= 1'b0;
            rgb_r       <= {(3 * CW){1'b0}};
            x_r         <= XW'(0);
            y_r         <= YW'(0);
            frame_cnt_r <= 16'd0;
        end else if (tick_s) begin
            state_r     <= state_nxt_s;
            h_r         <= h_nxt_s;
            v_r         <= v_nxt_s;
            mode_r      <= mode_nxt_s;
            grest_r     <= (state_nxt_s != ST_IDLE);
            hd_r        <= hs_s ? SYNC_ACT : ~SYNC_ACT;
            vd_r        <= vs_s ? SYNC_ACT : ~SYNC_ACT;
            den_r       <= den_nxt_s;
            rgb_r       <= den_nxt_s ? pat_rgb_s : {(3 * CW){1'b0}};
            x_r         <= x_nxt_s;
            y_r         <= y_nxt_s;
            frame_cnt_r <= frame_end_s ? frame_cnt_r + 16'd1 : frame_cnt_r;
        end else begin
            state_r <= state_r;
        end
    end

    // One-CLK strobe on the frame-end tick
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_stb_r <= 1'b0;
        end else begin
            frame_stb_r <= tick_s & frame_end_s;
        end
    end

    assign NCLK      = nclk_r;
    assign GREST     = grest_r;
    assign HD        = hd_r;
    assign VD        = vd_r;
    assign DEN       = den_r;
    assign R         = rgb_r[3*CW-1 -: CW];
    assign G         = rgb_r[2*CW-1 -: CW];
    assign B         = rgb_r[CW-1:0];
    assign X         = x_r;
    assign Y         = y_r;
    assign FRAME_CNT = frame_cnt_r;
    assign FRAME_STB = frame_stb_r;

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Scoreboard bench for lcd_timing_pattern_gen on a reduced 64x40 raster
// (72x44 total) so several whole frames fit in a short run.
module tb_lcd_timing_pattern_gen;

    localparam int HS = 2, HB = 3, HA = 64, HF = 3;
    localparam int VS = 1, VB = 2, VA = 40, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME_PIX = HT * VT;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);
    localparam logic [23:0] FG = 24'h123456;

    logic          CLK = 1'b0;
    logic          RST, EN;
    logic [1:0]    MODE;
    logic [23:0]   FG_RGB;
    logic          NCLK, GREST, HD, VD, DEN, FRAME_STB;
    logic [7:0]    R, G, B;
    logic [XW-1:0] X;
    logic [YW-1:0] Y;
    logic [15:0]   FRAME_CNT;

    lcd_timing_pattern_gen #(
        .CLK_DIV(2), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF), .SYNC_POL(0), .CW(8)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .FG_RGB(FG_RGB),
        .NCLK(NCLK), .GREST(GREST), .HD(HD), .VD(VD), .DEN(DEN),
        .R(R), .G(G), .B(B), .X(X), .Y(Y),
        .FRAME_CNT(FRAME_CNT), .FRAME_STB(FRAME_STB)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0, failures = 0;
    int   blank_viol = 0, stb_cnt = 0, timeouts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int x, input int y, input logic [23:0] rgb);
        exp_t e;
        e.x = x; e.y = y; e.rgb = rgb;
        sb_q.push_back(e);
    endtask

    // Advance to the next pixel, sampled at the first CLK falling edge with NCLK high.
    task automatic next_pix();
        int n = 0;
        while (NCLK !== 1'b0 && n < 16) begin @(negedge CLK); n++; end
        while (NCLK !== 1'b1 && n < 16) begin @(negedge CLK); n++; end
        if (n >= 16) timeouts++;
    endtask

    task automatic run_pix(input int n);
        for (int i = 0; i < n; i++) next_pix();
    endtask

    // Monitor: pops the scoreboard when the DUT shows the expected coordinate
    initial forever begin
        @(negedge CLK);
        if (RST === 1'b0) begin
            if (DEN === 1'b0 && {R, G, B} !== 24'h0) blank_viol++;
            if (FRAME_STB === 1'b1) stb_cnt++;
            if (sb_q.size() > 0 && DEN === 1'b1 && int'(X) == sb_q[0].x && int'(Y) == sb_q[0].y) begin
                check($sformatf("rgb@%0d,%0d", sb_q[0].x, sb_q[0].y), {8'h0, R, G, B}, {8'h0, sb_q[0].rgb});
                void'(sb_q.pop_front());
            end
        end
    end

    int hd_low, vd_low, den_n, den_rises, first_den, run, run_min, run_max, hd_fall2;
    bit prev_den, prev_hd, found;
    logic [15:0] held_cnt;

    initial begin
        RST = 1'b1; EN = 1'b0; MODE = 2'b00; FG_RGB = FG;
        repeat (20) @(negedge CLK);
        check("rst_nclk", NCLK, 0);
        check("rst_grest", GREST, 0);
        check("rst_hd_vd", {HD, VD}, 2'b11);
        check("rst_den", DEN, 0);
        check("rst_rgb", {R, G, B}, 0);
        check("rst_xy", {X, Y}, 0);
        check("rst_frame", {FRAME_CNT, FRAME_STB}, 0);

        RST = 1'b0;
        begin
            int   t = 0;
            logic p = NCLK;
            for (int i = 0; i < 8; i++) begin
                @(negedge CLK);
                if (NCLK !== p) t++;
                p = NCLK;
            end
            check("nclk_toggle", t, 8);
        end
        check("idle_grest", GREST, 0);
        check("idle_den", DEN, 0);
        check("idle_sync", {HD, VD}, 2'b11);
        check("idle_rgb", {R, G, B}, 0);

        // Frame A bars; frame B solid; frame C checkerboard; frame D ramp
        push(0, 0, 24'hFFFFFF);  push(12, 0, 24'hFFFF00); push(20, 0, 24'h00FFFF);
        push(63, 0, 24'h000000); push(35, 5, 24'hFF00FF); push(40, 5, 24'hFF0000);
        push(29, 20, 24'h00FF00); push(50, 39, 24'h0000FF);
        push(10, 3, FG); push(32, 20, FG); push(40, 30, FG); push(63, 39, FG);
        push(0, 0, FG); push(32, 0, 24'h0); push(31, 31, FG); push(32, 32, FG);
        push(5, 33, 24'h0); push(63, 39, FG);
        push(10, 0, 24'h282828); push(0, 1, 24'h000000); push(63, 7, 24'hFCFCFC);
        push(32, 10, 24'h808080);

        MODE = 2'b01;
        EN   = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            next_pix();
            if (GREST === 1'b1) found = 1;
        end
        check("grest_rise", found, 1);
        check("arm_idle", {HD, VD, DEN}, 3'b110);
        next_pix();
        check("start_sync", {HD, VD}, 2'b00);

        hd_low = 0; vd_low = 0; den_n = 0; den_rises = 0; first_den = -1;
        run = 0; run_min = 1000000; run_max = 0; hd_fall2 = -1;
        prev_den = 0; prev_hd = 0;
        for (int i = 0; i < FRAME_PIX; i++) begin
            if (i > 0) next_pix();
            if (i == 0) check("frame_cnt_a", FRAME_CNT, 0);
            if (i == 100) MODE = 2'b00;
            if (i == 221) check("first_xy", {DEN, X, Y}, {1'b1, XW'(0), YW'(0)});
            if (i == 42 * HT + 68) check("last_xy", {DEN, X, Y}, {1'b1, XW'(63), YW'(39)});
            if (HD === 1'b0) hd_low++;
            if (VD === 1'b0) vd_low++;
            if (HD === 1'b0 && prev_hd && hd_fall2 < 0) hd_fall2 = i;
            if (DEN === 1'b1) begin
                den_n++;
                if (!prev_den) begin
                    den_rises++;
                    if (first_den < 0) first_den = i;
                    run = 0;
                end
                run++;
            end else if (prev_den) begin
                if (run < run_min) run_min = run;
                if (run > run_max) run_max = run;
            end
            prev_den = (DEN === 1'b1);
            prev_hd  = (HD === 1'b1);
        end
        check("hd_low", hd_low, VT * HS);
        check("hd_period", hd_fall2, HT);
        check("vd_low", vd_low, HT * VS);
        check("den_count", den_n, HA * VA);
        check("den_lines", den_rises, VA);
        check("den_offset", first_den, (VS + VB) * HT + HS + HB);
        check("den_run", {run_min[15:0], run_max[15:0]}, {16'(HA), 16'(HA)});
        check("stb_before", stb_cnt, 0);

        next_pix();
        check("frame_cnt_b", FRAME_CNT, 1);
        check("stb_after", stb_cnt, 1);
        run_pix(1439);
        MODE = 2'b10;
        run_pix(FRAME_PIX - 1440);
        next_pix();
        check("frame_cnt_c", FRAME_CNT, 2);
        run_pix(1599);
        MODE = 2'b11;
        run_pix(FRAME_PIX - 1600);

        found = 0;
        for (int i = 0; i < FRAME_PIX && !found; i++) begin
            next_pix();
            if (DEN === 1'b1 && int'(X) == 40 && int'(Y) == 12) found = 1;
        end
        check("reach_x40", found, 1);
        check("frame_cnt_d", FRAME_CNT, 3);
        held_cnt = FRAME_CNT;
        EN = 1'b0;
        next_pix();
        check("dis_den", DEN, 0);
        check("dis_grest", GREST, 0);
        check("dis_sync", {HD, VD}, 2'b11);
        check("dis_rgb", {R, G, B}, 0);
        check("dis_cnt", FRAME_CNT, held_cnt);
        run_pix(5);
        check("dis_hold", {GREST, FRAME_CNT}, {1'b0, held_cnt});

        EN = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            next_pix();
            if (GREST === 1'b1) found = 1;
        end
        check("regrest", {found, HD, DEN}, 3'b110);
        next_pix();
        check("restart_sync", {HD, VD}, 2'b00);
        run_pix(3 * HT + 10);
        check("mid_line_den", DEN, 1);

        #2 RST = 1'b1;
        #1;
        check("arst_grest_den", {GREST, DEN}, 2'b00);
        check("arst_sync", {HD, VD}, 2'b11);
        check("arst_rgb", {R, G, B}, 0);
        check("arst_xy", {X, Y}, 0);
        check("arst_frame", {FRAME_CNT, FRAME_STB, NCLK}, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        check("sb_empty", sb_q.size(), 0);
        check("blank_rgb", blank_viol, 0);
        check("timeouts", timeouts, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
